// File: rtl/operand_stack_pkg.sv
// Shared definitions for the operand stack: opcode encoding and error codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package operand_stack_pkg;

   // Stack opcodes, one applied per clock.
   typedef enum logic [2:0] {
      stkNOP   = 3'd0,
      stkPUSH  = 3'd1,
      stkPOP   = 3'd2,
      stkPOP2  = 3'd3,
      stkREPL2 = 3'd4,
      stkDUP   = 3'd5,
      stkSWAP  = 3'd6,
      stkOVER  = 3'd7
   } stk_op_t;

   // Sticky error codes; the first error seen after reset is held.
   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_OVF  = 2'b01;
   localparam logic [1:0] ERR_UNF  = 2'b10;

endpackage

// File: rtl/stack_ram.sv
// DEPTH x W register array with two async read ports and two sync write ports.
// Latency: reads combinational; writes land on the rising clk edge.
// Backpressure: none; callers never write the same address on both ports.
module stack_ram #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_a,
   input  logic [AW-1:0] waddr_a,
   input  logic [W-1:0]  wdata_a,
   input  logic          we_b,
   input  logic [AW-1:0] waddr_b,
   input  logic [W-1:0]  wdata_b,
   input  logic [AW-1:0] raddr_a,
   input  logic [AW-1:0] raddr_b,
   output logic [W-1:0]  rdata_a,
   output logic [W-1:0]  rdata_b
);

   logic [W-1:0] mem [DEPTH];

   // Contents are never read while invalid, so the array carries no reset.
   always_ff @(posedge clk) begin
      if (we_a) mem[waddr_a] <= wdata_a;
      if (we_b) mem[waddr_b] <= wdata_b;
   end

   assign rdata_a = mem[raddr_a];
   assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/operand_stack.sv
// Operand stack feeding the ALU: tos/nos out, one push/pop/repl2/dup/swap/over per clock.
// Latency: op applied on the rising edge; tos/nos/count reflect it in the next cycle.
// Backpressure: none; overflow/underflow ops are dropped and flagged in sticky err/err_code.
module operand_stack
   import operand_stack_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   parameter int AW    = $clog2(DEPTH),
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          CLK,
   input  logic          reset,
   input  stk_op_t       op,
   input  logic [W-1:0]  push_data,
   input  logic [W-1:0]  alu_rslt,
   output logic [W-1:0]  tos,
   output logic [W-1:0]  nos,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full,
   output logic          err,
   output logic [1:0]    err_code
);

   logic [CW-1:0] cnt_m1;
   logic [CW-1:0] cnt_m2;
   logic [AW-1:0] top_addr;
   logic [AW-1:0] tos_addr;
   logic [AW-1:0] nos_addr;
   logic [W-1:0]  tos_raw;
   logic [W-1:0]  nos_raw;

   logic [1:0]    need;
   logic          grow;
   logic          dec1;
   logic          dec2;
   logic          we_a;
   logic          we_b;
   logic [AW-1:0] waddr_a;
   logic [AW-1:0] waddr_b;
   logic [W-1:0]  wdata_a;
   logic [W-1:0]  wdata_b;
   logic          unf;
   logic          ovf;
   logic          legal;
   logic [CW-1:0] count_nxt;

   // Address of the next free slot and of the two live operands. When count is
   // below 2 these wrap to garbage slots, but the outputs below mask them.
   assign cnt_m1   = count - CW'(1);
   assign cnt_m2   = count - CW'(2);
   assign top_addr = count[AW-1:0];
   assign tos_addr = cnt_m1[AW-1:0];
   assign nos_addr = cnt_m2[AW-1:0];

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign tos   = (count >= CW'(1)) ? tos_raw : '0;
   assign nos   = (count >= CW'(2)) ? nos_raw : '0;

   stack_ram #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (CLK),
      .we_a    (we_a & legal),
      .waddr_a (waddr_a),
      .wdata_a (wdata_a),
      .we_b    (we_b & legal),
      .waddr_b (waddr_b),
      .wdata_b (wdata_b),
      .raddr_a (tos_addr),
      .raddr_b (nos_addr),
      .rdata_a (tos_raw),
      .rdata_b (nos_raw)
   );

   // Decode the op into minimum depth, count change and array writes; gate on legality.
   always_comb begin
      need    = 2'd0;
      grow    = 1'b0;
      dec1    = 1'b0;
      dec2    = 1'b0;
      we_a    = 1'b0;
      we_b    = 1'b0;
      waddr_a = top_addr;
      waddr_b = nos_addr;
      wdata_a = push_data;
      wdata_b = tos_raw;
      case (op)
         stkPUSH: begin
            grow    = 1'b1;
            we_a    = 1'b1;
         end
         stkPOP: begin
            need    = 2'd1;
            dec1    = 1'b1;
         end
         stkPOP2: begin
            need    = 2'd2;
            dec2    = 1'b1;
         end
         stkREPL2: begin
            need    = 2'd2;
            dec1    = 1'b1;
            we_a    = 1'b1;
            waddr_a = nos_addr;
            wdata_a = alu_rslt;
         end
         stkDUP: begin
            need    = 2'd1;
            grow    = 1'b1;
            we_a    = 1'b1;
            wdata_a = tos_raw;
         end
         stkSWAP: begin
            need    = 2'd2;
            we_a    = 1'b1;
            waddr_a = tos_addr;
            wdata_a = nos_raw;
            we_b    = 1'b1;
            waddr_b = nos_addr;
            wdata_b = tos_raw;
         end
         stkOVER: begin
            need    = 2'd2;
            grow    = 1'b1;
            we_a    = 1'b1;
            wdata_a = nos_raw;
         end
         default: begin
         end
      endcase

      unf   = (count < CW'(need));
      ovf   = grow & full;
      legal = ~unf & ~ovf;

      count_nxt = count;
      if (legal) begin
         if (grow)      count_nxt = count + CW'(1);
         else if (dec1) count_nxt = cnt_m1;
         else if (dec2) count_nxt = cnt_m2;
      end
   end

   // Stack depth and sticky error state; the first error code after reset is kept.
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         count    <= '0;
         err      <= 1'b0;
         err_code <= ERR_NONE;
      end else begin
         count <= count_nxt;
         if (unf || ovf) begin
            err <= 1'b1;
            if (err_code == ERR_NONE) err_code <= ovf ? ERR_OVF : ERR_UNF;
         end
      end
   end

endmodule

// File: tb/tb_operand_stack.sv
// Directed self-checking bench for operand_stack.
// Latency: ops driven at negedge, results sampled 1ns after the following posedge.
// Backpressure: n/a.
module tb_operand_stack;
   import operand_stack_pkg::*;

   localparam int W     = 8;
   localparam int DEPTH = 16;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          CLK = 1'b0;
   logic          reset = 1'b0;
   stk_op_t       op = stkNOP;
   logic [W-1:0]  push_data = '0;
   logic [W-1:0]  alu_rslt = '0;
   logic [W-1:0]  tos;
   logic [W-1:0]  nos;
   logic [CW-1:0] count;
   logic          empty;
   logic          full;
   logic          err;
   logic [1:0]    err_code;

   int n_checks = 0;
   int n_fail   = 0;

   operand_stack #(.W(W), .DEPTH(DEPTH)) dut (
      .CLK       (CLK),
      .reset     (reset),
      .op        (op),
      .push_data (push_data),
      .alu_rslt  (alu_rslt),
      .tos       (tos),
      .nos       (nos),
      .count     (count),
      .empty     (empty),
      .full      (full),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 CLK = ~CLK;

   task automatic do_reset();
      @(negedge CLK);
      op    = stkNOP;
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic do_op(input stk_op_t o, input logic [W-1:0] d);
      @(negedge CLK);
      op        = o;
      push_data = d;
      @(posedge CLK);
      #1;
      op = stkNOP;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
      n_checks++; if (tos !== 8'h00)   begin n_fail++; $display("FAIL rst_tos: got %h want 00", tos); end
      n_checks++; if (nos !== 8'h00)   begin n_fail++; $display("FAIL rst_nos: got %h want 00", nos); end
      n_checks++; if (empty !== 1'b1)  begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
      n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
      n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL rst_err: got %b want 0", err); end
      n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL rst_code: got %b want 00", err_code); end
   endtask

   task automatic test_push_repl2();
      do_reset();
      do_op(stkPUSH, 8'h05);
      do_op(stkPUSH, 8'h03);
      n_checks++; if (count !== 5'd2)  begin n_fail++; $display("FAIL push_count: got %0d want 2", count); end
      n_checks++; if (tos !== 8'h03)   begin n_fail++; $display("FAIL push_tos: got %h want 03", tos); end
      n_checks++; if (nos !== 8'h05)   begin n_fail++; $display("FAIL push_nos: got %h want 05", nos); end
      n_checks++; if (empty !== 1'b0)  begin n_fail++; $display("FAIL push_empty: got %b want 0", empty); end
      n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL push_err: got %b want 0", err); end
      alu_rslt = 8'h08;
      do_op(stkREPL2, 8'h00);
      n_checks++; if (count !== 5'd1)  begin n_fail++; $display("FAIL repl2_count: got %0d want 1", count); end
      n_checks++; if (tos !== 8'h08)   begin n_fail++; $display("FAIL repl2_tos: got %h want 08", tos); end
      n_checks++; if (nos !== 8'h00)   begin n_fail++; $display("FAIL repl2_nos: got %h want 00", nos); end
      do_op(stkPUSH, 8'h11);
      do_op(stkPOP2, 8'h00);
      n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL pop2_count: got %0d want 0", count); end
      n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL pop2_err: got %b want 0", err); end
   endtask

   task automatic test_swap_over_dup();
      do_reset();
      do_op(stkPUSH, 8'hAA);
      do_op(stkPUSH, 8'hBB);
      do_op(stkSWAP, 8'h00);
      n_checks++; if (tos !== 8'hAA)   begin n_fail++; $display("FAIL swap_tos: got %h want AA", tos); end
      n_checks++; if (nos !== 8'hBB)   begin n_fail++; $display("FAIL swap_nos: got %h want BB", nos); end
      n_checks++; if (count !== 5'd2)  begin n_fail++; $display("FAIL swap_count: got %0d want 2", count); end
      do_op(stkOVER, 8'h00);
      n_checks++; if (count !== 5'd3)  begin n_fail++; $display("FAIL over_count: got %0d want 3", count); end
      n_checks++; if (tos !== 8'hBB)   begin n_fail++; $display("FAIL over_tos: got %h want BB", tos); end
      n_checks++; if (nos !== 8'hAA)   begin n_fail++; $display("FAIL over_nos: got %h want AA", nos); end
      do_op(stkDUP, 8'h00);
      n_checks++; if (count !== 5'd4)  begin n_fail++; $display("FAIL dup_count: got %0d want 4", count); end
      n_checks++; if (tos !== 8'hBB)   begin n_fail++; $display("FAIL dup_tos: got %h want BB", tos); end
      n_checks++; if (nos !== 8'hBB)   begin n_fail++; $display("FAIL dup_nos: got %h want BB", nos); end
      do_op(stkPOP, 8'h00);
      do_op(stkPOP, 8'h00);
      n_checks++; if (tos !== 8'hAA)   begin n_fail++; $display("FAIL pop_tos: got %h want AA", tos); end
      n_checks++; if (nos !== 8'hBB)   begin n_fail++; $display("FAIL pop_nos: got %h want BB", nos); end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_op(stkPUSH, 8'(i));
      n_checks++; if (full !== 1'b1)   begin n_fail++; $display("FAIL ovf_full: got %b want 1", full); end
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_fillcount: got %0d want 16", count); end
      n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL ovf_preerr: got %b want 0", err); end
      do_op(stkPUSH, 8'hFF);
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_count: got %0d want 16", count); end
      n_checks++; if (tos !== 8'h0F)   begin n_fail++; $display("FAIL ovf_tos: got %h want 0F", tos); end
      n_checks++; if (nos !== 8'h0E)   begin n_fail++; $display("FAIL ovf_nos: got %h want 0E", nos); end
      n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL ovf_err: got %b want 1", err); end
      n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL ovf_code: got %b want 01", err_code); end
      do_op(stkDUP, 8'h00);
      n_checks++; if (count !== 5'd16) begin n_fail++; $display("FAIL ovf_dupcount: got %0d want 16", count); end
      do_op(stkPOP, 8'h00);
      n_checks++; if (count !== 5'd15) begin n_fail++; $display("FAIL ovf_popcount: got %0d want 15", count); end
      n_checks++; if (tos !== 8'h0E)   begin n_fail++; $display("FAIL ovf_poptos: got %h want 0E", tos); end
      n_checks++; if (full !== 1'b0)   begin n_fail++; $display("FAIL ovf_popfull: got %b want 0", full); end
      n_checks++; if (err_code !== 2'b01) begin n_fail++; $display("FAIL ovf_keepcode: got %b want 01", err_code); end
   endtask

   task automatic test_underflow();
      do_reset();
      do_op(stkPOP, 8'h00);
      n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL unf_err: got %b want 1", err); end
      n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL unf_code: got %b want 10", err_code); end
      n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL unf_count: got %0d want 0", count); end
      do_op(stkPUSH, 8'h01);
      n_checks++; if (count !== 5'd1)  begin n_fail++; $display("FAIL unf_pushcount: got %0d want 1", count); end
      n_checks++; if (tos !== 8'h01)   begin n_fail++; $display("FAIL unf_pushtos: got %h want 01", tos); end
      n_checks++; if (err !== 1'b1)    begin n_fail++; $display("FAIL unf_stickyerr: got %b want 1", err); end
      n_checks++; if (err_code !== 2'b10) begin n_fail++; $display("FAIL unf_stickycode: got %b want 10", err_code); end
      do_op(stkSWAP, 8'h00);
      n_checks++; if (count !== 5'd1)  begin n_fail++; $display("FAIL unf_swapcount: got %0d want 1", count); end
      n_checks++; if (tos !== 8'h01)   begin n_fail++; $display("FAIL unf_swaptos: got %h want 01", tos); end
      alu_rslt = 8'h77;
      do_op(stkREPL2, 8'h00);
      n_checks++; if (tos !== 8'h01)   begin n_fail++; $display("FAIL unf_repltos: got %h want 01", tos); end
   endtask

   task automatic test_async_reset();
      do_reset();
      do_op(stkPOP, 8'h00);
      do_op(stkPUSH, 8'h21);
      do_op(stkPUSH, 8'h22);
      do_op(stkPUSH, 8'h23);
      n_checks++; if (count !== 5'd3)  begin n_fail++; $display("FAIL ar_precount: got %0d want 3", count); end
      @(negedge CLK);
      #2;
      reset = 1'b1;
      #1;
      n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL ar_count: got %0d want 0", count); end
      n_checks++; if (tos !== 8'h00)   begin n_fail++; $display("FAIL ar_tos: got %h want 00", tos); end
      n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL ar_err: got %b want 0", err); end
      n_checks++; if (err_code !== 2'b00) begin n_fail++; $display("FAIL ar_code: got %b want 00", err_code); end
      op        = stkPUSH;
      push_data = 8'h55;
      @(posedge CLK);
      #1;
      n_checks++; if (count !== 5'd0)  begin n_fail++; $display("FAIL ar_dropop: got %0d want 0", count); end
      op = stkNOP;
      @(negedge CLK);
      reset = 1'b0;
      do_op(stkPUSH, 8'h66);
      n_checks++; if (tos !== 8'h66)   begin n_fail++; $display("FAIL ar_resume: got %h want 66", tos); end
   endtask

   initial begin
      test_reset();
      test_push_repl2();
      test_swap_over_dup();
      test_overflow();
      test_underflow();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
